// File: rtl/vmx_mm_wrapper_spec.sv
`default_nettype none
// vmx_mm_wrapper_spec: memory-mapped 4x4 unsigned 16-bit matrix multiply (C = A x B), 64-bit memory port.
// Revision 1.0 - initial release.
module vmx_mm_wrapper_spec (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rbase_addr,
    input  logic [7:0]   wbase_addr,
    input  logic [31:0]  ctrl,
    output logic [7:0]   addr,
    output logic         wr_en,
    input  logic [63:0]  d_i,
    output logic [127:0] d_o,
    output logic [31:0]  flag
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_COMP  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]         r_state;
    logic [2:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_ctrl1;
    logic [7:0]         r_rbase;
    logic [7:0]         r_wbase;
    logic [7:0][63:0]   r_buf;
    logic [3:0][127:0]  r_res;

    logic               w_start;
    logic [3:0][3:0][15:0] w_a;
    logic [3:0][3:0][15:0] w_b;
    logic [3:0][3:0][31:0] w_c;
    logic [3:0][127:0]  w_row;
    logic               w_unused_ctrl;

    assign w_unused_ctrl = ^{ctrl[31:2], ctrl[0]};
    assign w_start       = ctrl[1] & ~r_ctrl1 & (r_state == S_IDLE);

    // Buffer words 0..3 are A rows, 4..7 are B rows; column 0 sits in the MSBs.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        for (genvar gk = 0; gk < 4; gk++) begin : g_col
            assign w_a[gi][gk] = r_buf[gi][63-16*gk -: 16];
            assign w_b[gi][gk] = r_buf[4+gi][63-16*gk -: 16];
        end
        for (genvar gj = 0; gj < 4; gj++) begin : g_dot
            assign w_c[gi][gj] = 32'(w_a[gi][0]) * 32'(w_b[0][gj])
                               + 32'(w_a[gi][1]) * 32'(w_b[1][gj])
                               + 32'(w_a[gi][2]) * 32'(w_b[2][gj])
                               + 32'(w_a[gi][3]) * 32'(w_b[3][gj]);
        end
        assign w_row[gi] = {w_c[gi][3], w_c[gi][2], w_c[gi][1], w_c[gi][0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ctrl1 <= 1'b0;
            r_rbase <= '0;
            r_wbase <= '0;
            r_buf   <= '0;
            r_res   <= '0;
        end else begin
            r_ctrl1 <= ctrl[1];
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_rbase <= rbase_addr;
                        r_wbase <= wbase_addr;
                        r_cnt   <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_buf[r_cnt] <= d_i;
                    if (r_cnt == 3'd7) begin
                        r_cnt   <= '0;
                        r_state <= S_COMP;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_COMP: begin
                    r_res   <= w_row;
                    r_cnt   <= '0;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_cnt == 3'd3) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset silences them at once.
    always_comb begin
        addr  = '0;
        wr_en = 1'b0;
        d_o   = '0;
        case (r_state)
            S_READ: addr = r_rbase + {5'd0, r_cnt};
            S_WRITE: begin
                addr  = r_wbase + {5'd0, r_cnt[1:0], 1'b0};
                wr_en = 1'b1;
                d_o   = r_res[r_cnt[1:0]];
            end
            default: ;
        endcase
    end

    assign flag = {30'd0, r_done, r_busy};

endmodule
`default_nettype wire

// File: tb/tb_vmx_mm_wrapper_spec.sv
`default_nettype none
`timescale 1ns/1ps
// tb_vmx_mm_wrapper_spec: self-checking bench with a memory model and an arithmetic reference for C = A x B.
module tb_vmx_mm_wrapper_spec;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rbase_addr;
    logic [7:0]   wbase_addr;
    logic [31:0]  ctrl;
    logic [7:0]   addr;
    logic         wr_en;
    logic [63:0]  d_i;
    logic [127:0] d_o;
    logic [31:0]  flag;

    int checks = 0;
    int errors = 0;

    logic [63:0]  mem [256];
    int unsigned  ma [4][4];
    int unsigned  mb [4][4];
    logic [31:0]  exp_c [4][4];

    vmx_mm_wrapper_spec dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rbase_addr (rbase_addr),
        .wbase_addr (wbase_addr),
        .ctrl       (ctrl),
        .addr       (addr),
        .wr_en      (wr_en),
        .d_i        (d_i),
        .d_o        (d_o),
        .flag       (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign d_i = mem[addr];

    always @(posedge clk) begin
        if (wr_en) begin
            mem[addr]              <= d_o[63:0];
            mem[8'(addr + 8'd1)]   <= d_o[127:64];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compute_model();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int unsigned acc;
                acc = 0;
                for (int k = 0; k < 4; k++) acc += ma[i][k] * mb[k][j];
                exp_c[i][j] = acc;
            end
    endtask

    task automatic load_mem(input logic [7:0] rb);
        for (int r = 0; r < 4; r++) begin
            mem[8'(rb + 8'(r))]     = {ma[r][0][15:0], ma[r][1][15:0], ma[r][2][15:0], ma[r][3][15:0]};
            mem[8'(rb + 8'(4 + r))] = {mb[r][0][15:0], mb[r][1][15:0], mb[r][2][15:0], mb[r][3][15:0]};
        end
        compute_model();
    endtask

    task automatic randomize_mats();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = $urandom_range(0, 65535);
                mb[i][j] = $urandom_range(0, 65535);
            end
    endtask

    task automatic check_mem(input logic [7:0] wb, input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s word%0d", tag, 2*i), {64'd0, mem[8'(wb + 8'(2*i))]},
                {64'd0, exp_c[i][1], exp_c[i][0]});
            chk($sformatf("%s word%0d", tag, 2*i+1), {64'd0, mem[8'(wb + 8'(2*i+1))]},
                {64'd0, exp_c[i][3], exp_c[i][2]});
        end
    endtask

    // Pulse start at a negedge; observation n is taken in the cycle after the n-th edge past acceptance.
    task automatic run_job(input logic [7:0] rb, input logic [7:0] wb, input bit busy_pulse, input int abort_at);
        logic [7:0]   e_addr;
        logic         e_we;
        logic [31:0]  e_flag;
        logic [127:0] e_do;
        rbase_addr = rb;
        wbase_addr = wb;
        ctrl = ($urandom & 32'hFFFF_FFFD) | 32'h2;
        @(posedge clk);
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (n == 0) begin
                ctrl       = $urandom & 32'hFFFF_FFFD;
                rbase_addr = 8'($urandom);
                wbase_addr = 8'($urandom);
            end
            if (busy_pulse && n == 3) ctrl = ctrl | 32'h2;
            if (busy_pulse && n == 4) ctrl = ctrl & 32'hFFFF_FFFD;
            e_addr = 8'd0; e_we = 1'b0; e_flag = 32'd1; e_do = '0;
            if (n < 8) e_addr = rb + 8'(n);
            else if (n >= 9 && n < 13) begin
                e_addr = wb + 8'(2 * (n - 9));
                e_we   = 1'b1;
                e_do   = {exp_c[n-9][3], exp_c[n-9][2], exp_c[n-9][1], exp_c[n-9][0]};
            end else if (n == 13) e_flag = 32'd2;
            chk($sformatf("addr n=%0d", n), {120'd0, addr}, {120'd0, e_addr});
            chk($sformatf("wr_en n=%0d", n), {127'd0, wr_en}, {127'd0, e_we});
            chk($sformatf("flag n=%0d", n), {96'd0, flag}, {96'd0, e_flag});
            chk($sformatf("d_o n=%0d", n), d_o, e_do);
            if (n == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort wr_en", {127'd0, wr_en}, 128'd0);
                chk("abort flag", {96'd0, flag}, 128'd0);
                chk("abort addr", {120'd0, addr}, 128'd0);
                chk("abort d_o", d_o, 128'd0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int m = 0; m < 3; m++) begin
                    @(negedge clk);
                    chk($sformatf("post-abort idle flag m=%0d", m), {96'd0, flag}, 128'd0);
                    chk($sformatf("post-abort idle wr_en m=%0d", m), {127'd0, wr_en}, 128'd0);
                end
                return;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ctrl = '0; rbase_addr = '0; wbase_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset addr", {120'd0, addr}, 128'd0);
        chk("reset wr_en", {127'd0, wr_en}, 128'd0);
        chk("reset d_o", d_o, 128'd0);
        chk("reset flag", {96'd0, flag}, 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed multiply from the reference example.
        ma = '{'{1,2,3,4}, '{5,6,7,8}, '{4,3,2,1}, '{8,7,6,5}};
        mb = ma;
        load_mem(8'd0);
        run_job(8'd0, 8'd8, 1'b0, -1);
        check_mem(8'd8, "func");
        chk("func word8 literal", {64'd0, mem[8]}, {64'd0, 32'd51, 32'd55});
        chk("func word9 literal", {64'd0, mem[9]}, {64'd0, 32'd43, 32'd47});
        chk("func word14 literal", {64'd0, mem[14]}, {64'd0, 32'd111, 32'd107});

        // Repeat run with a start pulse while busy.
        repeat (20) @(negedge clk);
        for (int i = 8; i < 16; i++) mem[i] = '0;
        run_job(8'd0, 8'd8, 1'b1, -1);
        check_mem(8'd8, "repeat");

        // Read address wrap.
        randomize_mats();
        load_mem(8'd252);
        run_job(8'd252, 8'd100, 1'b0, -1);
        check_mem(8'd100, "wrap");

        // Saturated operands exercise the modulo-2^32 sum.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin ma[i][j] = 32'hFFFF; mb[i][j] = 32'hFFFF; end
        load_mem(8'd40);
        run_job(8'd40, 8'd200, 1'b0, -1);
        check_mem(8'd200, "ovf");
        chk("ovf literal", {64'd0, mem[200]}, {64'd0, 32'hFFF8_0004, 32'hFFF8_0004});

        // Random jobs, write window possibly wrapping.
        for (int t = 0; t < 4; t++) begin
            logic [7:0] rb, wb;
            rb = 8'($urandom);
            wb = 8'($urandom);
            randomize_mats();
            load_mem(rb);
            run_job(rb, wb, 1'(t & 1), -1);
            check_mem(wb, $sformatf("rand%0d", t));
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Async reset during the second WRITE cycle: only row 0 lands in memory.
        randomize_mats();
        load_mem(8'd16);
        for (int i = 0; i < 8; i++) mem[48 + i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
        run_job(8'd16, 8'd48, 1'b0, 10);
        chk("abort row0 lo", {64'd0, mem[48]}, {64'd0, exp_c[0][1], exp_c[0][0]});
        chk("abort row0 hi", {64'd0, mem[49]}, {64'd0, exp_c[0][3], exp_c[0][2]});
        for (int i = 2; i < 8; i++)
            chk($sformatf("abort untouched word%0d", i), {64'd0, mem[48 + i]},
                {64'd0, 64'hDEAD_BEEF_0000_0000 | 64'(i)});
        run_job(8'd16, 8'd48, 1'b0, -1);
        check_mem(8'd48, "recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vmx_mm_wrapper_spec.md
# vmx_mm_wrapper_spec

Memory-mapped 4x4 matrix-multiply engine for the AI platform's vector/matrix (VMX) datapath. When a start is detected on its control word, it reads two 4x4 matrices of unsigned 16-bit elements from a 64-bit-wide single-port memory and computes C = A × B. Each row of C (four 32-bit results) is written back as two consecutive 64-bit words. Status is reported on a 32-bit flag word for a host register interface.

## Interface
Parameters: none (geometry fixed at 4x4, 16-bit in, 32-bit out).

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rbase_addr  in  8  word address of A row 0; A rows at +0..+3, B rows at +4..+7
- wbase_addr  in  8  word address of C row 0; C row i occupies +2i and +2i+1
- ctrl  in  32  control word; bit 1 = start, other bits ignored
- addr  out  8  memory word address (read or write)
- wr_en  out  1  write strobe; memory stores d_o[63:0] at addr and d_o[127:64] at addr+1 on the same clock edge
- d_i  in  64  read data; combinational from addr within the same cycle
- d_o  out  128  write data (one C row)
- flag  out  32  status: bit 0 busy, bit 1 done, bits 31:2 zero

## Operation
- Input word packing: element column j sits at d_i[63-16j -: 16], so {e0,e1,e2,e3} has e0 in the MSBs. Word rbase+r is A row r; word rbase+4+r is B row r.
- Output packing: C[i][j] is at d_o[32j +: 32]. Memory word wbase+2i holds {C[i][1],C[i][0]}, and wbase+2i+1 holds {C[i][3],C[i][2]}.
- Arithmetic: C[i][j] = sum over k of A[i][k]·B[k][j]. Operands are unsigned 16-bit, products are 32-bit, and the sum wraps modulo 2^32.
- Start: a rising edge of ctrl[1], detected using a registered copy of ctrl[1], accepted only in IDLE. rbase_addr and wbase_addr are latched on acceptance. A start while busy is ignored.
- FSM states:
  - IDLE: wait for start. On start, clear done, set busy, go to READ with cnt=0.
  - READ: addr = rbase+cnt. Capture d_i into buffer[cnt] each edge. After cnt=7, go to COMP.
  - COMP: one cycle. Compute all 16 results into a result register.
  - WRITE: addr = wbase+2·cnt, wr_en=1, d_o = C row cnt. After cnt=3, go to IDLE with busy=0 and done=1.
- Addresses wrap modulo 256.
- Outside WRITE: wr_en=0, d_o=0, addr=0.
- done is sticky until the next accepted start or reset.

## Timing
- Reset (asynchronous): state IDLE, cnt=0, busy=0, done=0, buffers/results=0. Outputs: addr=0, wr_en=0, d_o=0, flag=0.
- Start sampling: ctrl[1] must be high across at least one rising clk edge.
- Cycle count from the edge that accepts start: 8 READ cycles, 1 COMP cycle, 4 WRITE cycles. busy falls and done rises on the 13th edge after acceptance.
- The engine is re-startable 1 cycle after done. Back-to-back jobs need at most 15 cycles.
- Reset during any state aborts immediately. No further writes occur, and partially written results remain in memory.

## Test plan
- Functional multiply: memory[0..7] = {1,2,3,4},{5,6,7,8},{4,3,2,1},{8,7,6,5} repeated twice; rbase=0, wbase=8; pulse ctrl[1].
  - Required C rows: [55,51,47,43], [127,123,119,115], [35,39,43,47], [107,111,115,119].
  - Word 8 = {32'd51,32'd55} and word 9 = {32'd43,32'd47}; the remaining rows land in words 10..15.
  - flag=2 afterwards.
- Repeat run: a second ctrl[1] pulse about 20 cycles later produces identical words 8..15. flag reads 1 during the run and 2 after it.
- Cycle check:
  - wr_en is high for exactly 4 cycles, with addr 8, 10, 12, 14.
  - Read addr sequence is 0..7.
  - done asserts 13 edges after the start edge.
- Busy start: pulse ctrl[1] during READ. The run is unaffected, with no restart and the same cycle count.
- Wrap and overflow:
  - rbase=252: reads addresses 252..255 then 0..3.
  - All elements 0xFFFF: C = 4·0xFFFE0001 mod 2^32 = 0xFFF80004.
- Asynchronous reset mid-WRITE: wr_en and flag go to 0 immediately without a clock edge, and FSM returns to IDLE.
